conv2d_sched: RTL
=================

// Module: conv2d_sched
// PURPOSE
//  Sequencer for a time-multiplexed conv2d datapath: walks every (oc,oh,ow,ic,kh,kw) tap of one
//  convolution job and issues one tap per valid/ready handshake to a single MAC + bias/round stage.
//  Drives input/weight/bias/output addresses, zero-pad flag and accumulator clear/last strobes.
//  Index conventions and accumulation order match the combinational conv2d (identical results).
// PARAMETERS
//  IN_CH    1  input channels
//  OUT_CH   1  output channels
//  IN_H     1  input height
//  IN_W     1  input width
//  K        3  square kernel size
//  STRIDE   1  stride, both dims
//  PADDING  0  zero padding, each side
//  Derived: OUT_H=(IN_H+2*PADDING-K)/STRIDE+1, OUT_W likewise; IN_AW=max(1,$clog2(IN_CH*IN_H*IN_W)),
//  W_AW=max(1,$clog2(OUT_CH*IN_CH*K*K)), O_AW=max(1,$clog2(OUT_CH*OUT_H*OUT_W)), B_AW=max(1,$clog2(OUT_CH))
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      job request; sampled only in IDLE
//  busy       out  1      high while in RUN
//  done       out  1      one-cycle pulse after final tap handshake
//  tap_valid  out  1      tap fields valid
//  tap_ready  in   1      MAC accepts tap
//  in_addr    out  IN_AW  (ic*IN_H+h)*IN_W+w; 0 when in_pad
//  in_pad     out  1      tap lies in padding; MAC uses 0 as operand
//  w_addr     out  W_AW   ((oc*IN_CH+ic)*K+kh)*K+kw
//  bias_addr  out  B_AW   oc
//  out_addr   out  O_AW   (oc*OUT_H+oh)*OUT_W+ow
//  acc_clr    out  1      first tap of output pixel (ic=kh=kw=0)
//  acc_last   out  1      last tap of pixel; MAC adds bias, rounds, writes out_addr
// BEHAVIOUR
//  - Async reset: state=IDLE, all counters 0, every output 0 (stall_cnt too).
//  - FSM IDLE -> RUN on start=1 (first tap presented the next cycle); RUN -> DONE on handshake of
//    the final tap; DONE -> IDLE unconditionally (done=1 in DONE only). start ignored in RUN/DONE.
//  - RUN: tap_valid=1 constantly; all tap fields registered, held stable while tap_ready=0.
//    Counters advance only on tap_valid&&tap_ready; kw innermost, then kh, ic, ow, oh, oc outermost.
//  - h=oh*STRIDE+kh-PADDING, w=ow*STRIDE+kw-PADDING as signed int; in_pad=1 if h<0|h>=IN_H|w<0|w>=IN_W.
//  - Job length: OUT_CH*OUT_H*OUT_W*IN_CH*K*K handshakes; min start->done latency = taps+1 cycles.
//  - acc_clr and acc_last both 1 on the same tap when IN_CH*K*K==1.
//  - Tap fields return to 0 and tap_valid falls in the DONE cycle; a new start is accepted the cycle after done.
//  - Reset mid-job aborts immediately; no done is issued for the aborted job.
// CONFIGURATION
//  CONV2D_SCHED_PERF_EN defined: adds output stall_cnt [31:0]; cleared when start is accepted,
//    +1 each RUN cycle with tap_valid&&!tap_ready, saturates at 2^32-1, held after done.
//  Not defined: no stall_cnt port/logic; all other behaviour identical.
// TESTING
//  1) IN_CH=OUT_CH=1, 3x3 in, K=3, P=0: start @c0 -> taps c1..c9, w_addr 0..8, in_addr 0..8,
//     acc_clr @c1, acc_last @c9, out_addr 0, done @c10 only.
//  2) 2x2 in, K=3, P=1 (OUT 2x2): 36 taps; pixel 0 taps kh=0 and (1,0) have in_pad=1, in_addr=0;
//     tap (1,1) in_pad=0, in_addr=0; out_addr steps 0,1,2,3 at each acc_last.
//  3) 5x5 in, K=3, STRIDE=2: pixel (0,1) first tap in_addr=2, last tap in_addr=14, out_addr=1.
//  4) tap_ready low 3 cycles mid-job: fields stable, handshake count unchanged; PERF_EN -> stall_cnt=3.
//  5) start pulsed during RUN and DONE: ignored, one done per job; restart next cycle after done works.
//  6) rst_n low mid-job: outputs 0 asynchronously, no done; new start runs full job from tap 0.

Source files
------------

// File: rtl/conv2d_sched.sv
// conv2d_sched: tap sequencer for a time-multiplexed conv2d datapath.
// Walks oc, oh, ow, ic, kh, kw (kw innermost) and presents one registered tap
// per valid/ready handshake to a single MAC + bias/round stage.
// Optional macro CONV2D_SCHED_PERF_EN adds the stall_cnt output.
module conv2d_sched #(
    parameter int IN_CH   = 1,
    parameter int OUT_CH  = 1,
    parameter int IN_H    = 1,
    parameter int IN_W    = 1,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int PADDING = 0,
    localparam int OUT_H  = (IN_H + 2*PADDING - K) / STRIDE + 1,
    localparam int OUT_W  = (IN_W + 2*PADDING - K) / STRIDE + 1,
    localparam int OH_N   = (OUT_H < 1) ? 1 : OUT_H,
    localparam int OW_N   = (OUT_W < 1) ? 1 : OUT_W,
    localparam int IN_AW  = ($clog2(IN_CH*IN_H*IN_W) > 0) ? $clog2(IN_CH*IN_H*IN_W) : 1,
    localparam int W_AW   = ($clog2(OUT_CH*IN_CH*K*K) > 0) ? $clog2(OUT_CH*IN_CH*K*K) : 1,
    localparam int O_AW   = ($clog2(OUT_CH*OH_N*OW_N) > 0) ? $clog2(OUT_CH*OH_N*OW_N) : 1,
    localparam int B_AW   = ($clog2(OUT_CH) > 0) ? $clog2(OUT_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic [IN_AW-1:0] in_addr,
    output logic             in_pad,
    output logic [W_AW-1:0]  w_addr,
    output logic [B_AW-1:0]  bias_addr,
    output logic [O_AW-1:0]  out_addr,
    output logic             acc_clr,
`ifdef CONV2D_SCHED_PERF_EN
    output logic             acc_last,
    output logic [31:0]      stall_cnt
`else
    output logic             acc_last
`endif
);

    localparam int CW_K  = ($clog2(K) > 0) ? $clog2(K) : 1;
    localparam int CW_IC = ($clog2(IN_CH) > 0) ? $clog2(IN_CH) : 1;
    localparam int CW_OW = ($clog2(OW_N) > 0) ? $clog2(OW_N) : 1;
    localparam int CW_OH = ($clog2(OH_N) > 0) ? $clog2(OH_N) : 1;
    localparam int CW_OC = ($clog2(OUT_CH) > 0) ? $clog2(OUT_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [CW_K-1:0]  kw_idx, kh_idx, kw_n, kh_n, kw_s, kh_s;
    logic [CW_IC-1:0] ic_idx, ic_n, ic_s;
    logic [CW_OW-1:0] ow_idx, ow_n, ow_s;
    logic [CW_OH-1:0] oh_idx, oh_n, oh_s;
    logic [CW_OC-1:0] oc_idx, oc_n, oc_s;
    logic             final_tap;

    logic             f_pad, f_clr, f_last;
    logic [IN_AW-1:0] f_in;
    logic [W_AW-1:0]  f_w;
    logic [B_AW-1:0]  f_b;
    logic [O_AW-1:0]  f_o;

    // Next tap indices: nested odometer, kw fastest, oc slowest
    always_comb begin
        kw_n      = kw_idx;
        kh_n      = kh_idx;
        ic_n      = ic_idx;
        ow_n      = ow_idx;
        oh_n      = oh_idx;
        oc_n      = oc_idx;
        final_tap = 1'b0;
        if (kw_idx != CW_K'(K-1)) begin
            kw_n = kw_idx + 1'b1;
        end else begin
            kw_n = '0;
            if (kh_idx != CW_K'(K-1)) begin
                kh_n = kh_idx + 1'b1;
            end else begin
                kh_n = '0;
                if (ic_idx != CW_IC'(IN_CH-1)) begin
                    ic_n = ic_idx + 1'b1;
                end else begin
                    ic_n = '0;
                    if (ow_idx != CW_OW'(OW_N-1)) begin
                        ow_n = ow_idx + 1'b1;
                    end else begin
                        ow_n = '0;
                        if (oh_idx != CW_OH'(OH_N-1)) begin
                            oh_n = oh_idx + 1'b1;
                        end else begin
                            oh_n = '0;
                            if (oc_idx != CW_OC'(OUT_CH-1)) begin
                                oc_n = oc_idx + 1'b1;
                            end else begin
                                oc_n      = '0;
                                final_tap = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Tap fields for the tap about to be registered (tap 0 when launching from IDLE)
    always_comb begin : field_calc
        int h;
        int w;
        kw_s   = (state == RUN) ? kw_n : '0;
        kh_s   = (state == RUN) ? kh_n : '0;
        ic_s   = (state == RUN) ? ic_n : '0;
        ow_s   = (state == RUN) ? ow_n : '0;
        oh_s   = (state == RUN) ? oh_n : '0;
        oc_s   = (state == RUN) ? oc_n : '0;
        h      = int'(oh_s) * STRIDE + int'(kh_s) - PADDING;
        w      = int'(ow_s) * STRIDE + int'(kw_s) - PADDING;
        f_pad  = (h < 0) || (h >= IN_H) || (w < 0) || (w >= IN_W);
        f_in   = f_pad ? '0 : IN_AW'((int'(ic_s) * IN_H + h) * IN_W + w);
        f_w    = W_AW'(((int'(oc_s) * IN_CH + int'(ic_s)) * K + int'(kh_s)) * K + int'(kw_s));
        f_b    = B_AW'(oc_s);
        f_o    = O_AW'((int'(oc_s) * OH_N + int'(oh_s)) * OW_N + int'(ow_s));
        f_clr  = (ic_s == '0) && (kh_s == '0) && (kw_s == '0);
        f_last = (ic_s == CW_IC'(IN_CH-1)) && (kh_s == CW_K'(K-1)) && (kw_s == CW_K'(K-1));
    end

    // Control FSM with registered tap fields, strobes and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            {kw_idx, kh_idx, ic_idx, ow_idx, oh_idx, oc_idx} <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tap_valid <= 1'b0;
            in_addr   <= '0;
            in_pad    <= 1'b0;
            w_addr    <= '0;
            bias_addr <= '0;
            out_addr  <= '0;
            acc_clr   <= 1'b0;
            acc_last  <= 1'b0;
`ifdef CONV2D_SCHED_PERF_EN
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        tap_valid <= 1'b1;
                        {kw_idx, kh_idx, ic_idx, ow_idx, oh_idx, oc_idx} <= '0;
                        in_addr   <= f_in;
                        in_pad    <= f_pad;
                        w_addr    <= f_w;
                        bias_addr <= f_b;
                        out_addr  <= f_o;
                        acc_clr   <= f_clr;
                        acc_last  <= f_last;
`ifdef CONV2D_SCHED_PERF_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    if (tap_ready) begin
                        if (final_tap) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            tap_valid <= 1'b0;
                            {kw_idx, kh_idx, ic_idx, ow_idx, oh_idx, oc_idx} <= '0;
                            in_addr   <= '0;
                            in_pad    <= 1'b0;
                            w_addr    <= '0;
                            bias_addr <= '0;
                            out_addr  <= '0;
                            acc_clr   <= 1'b0;
                            acc_last  <= 1'b0;
                        end else begin
                            {kw_idx, kh_idx, ic_idx, ow_idx, oh_idx, oc_idx} <=
                                {kw_n, kh_n, ic_n, ow_n, oh_n, oc_n};
                            in_addr   <= f_in;
                            in_pad    <= f_pad;
                            w_addr    <= f_w;
                            bias_addr <= f_b;
                            out_addr  <= f_o;
                            acc_clr   <= f_clr;
                            acc_last  <= f_last;
                        end
                    end
`ifdef CONV2D_SCHED_PERF_EN
                    else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
